// File: rtl/cpu_pkg.sv
// Shared core package: architectural sizes, opcode/ALU constants and the
// decode-to-issue bundle used across the pipeline.
package cpu_pkg;

    localparam int CPU_ADDR_W   = 5;
    localparam int CPU_NUM_REGS = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic [CPU_ADDR_W-1:0] rs1;
        logic [CPU_ADDR_W-1:0] rs2;
        logic [1:0]            src_used;
        logic                  wen;
        logic [CPU_ADDR_W-1:0] rd;
        logic                  spec;
    } issue_t;

endpackage

// File: rtl/sb_popcount.sv
// Parametrised population count of an N-bit vector.
module sb_popcount #(
    parameter int N  = 32,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] count
);

    // Ripple sum of all set bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending destinations of variable-latency
// producers, gates issue on RAW/WAW hazards and an outstanding limit, and
// squashes speculatively issued entries on a branch flush.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS        = CPU_NUM_REGS,
    parameter int ADDR_W          = CPU_ADDR_W,
    parameter int NUM_WB          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ZERO_HARDWIRED  = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic                                 issue_valid_i,
    input  logic [ADDR_W-1:0]                    issue_rs1_i,
    input  logic [ADDR_W-1:0]                    issue_rs2_i,
    input  logic [1:0]                           issue_use_i,
    input  logic                                 issue_wen_i,
    input  logic [ADDR_W-1:0]                    issue_rd_i,
    input  logic                                 issue_spec_i,
    output logic                                 issue_ready_o,
    input  logic [NUM_WB-1:0]                    wb_valid_i,
    input  logic [NUM_WB*ADDR_W-1:0]             wb_rd_i,
    input  logic                                 resolve_i,
    input  logic                                 flush_i,
    output logic [NUM_REGS-1:0]                  busy_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int POP_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] busy_reg, busy_next;
    logic [NUM_REGS-1:0] spec_reg, spec_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                err_reg, err_next;

    logic [NUM_REGS-1:0]             rd_dec;
    logic [NUM_WB-1:0][NUM_REGS-1:0] wb_dec;
    logic [NUM_REGS-1:0]             wb_hit;
    logic [NUM_REGS-1:0]             removed_mask;
    logic [NUM_REGS-1:0]             set_mask;
    logic [POP_W-1:0]                removed_cnt;
    logic [POP_W-1:0]                busy_cnt;
    logic                            wb_err;
    logic                            rd_is_zero;
    logic                            accept;

    // One-hot decode of the issue destination and of every write-back port.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign rd_dec[gi] = (issue_rd_i == ADDR_W'(gi));
            for (genvar gk = 0; gk < NUM_WB; gk++) begin : g_wb
                assign wb_dec[gk][gi] = wb_valid_i[gk] &&
                                        (wb_rd_i[gk*ADDR_W +: ADDR_W] == ADDR_W'(gi));
            end
        end
    endgenerate

    assign rd_is_zero = (ZERO_HARDWIRED != 0) && (issue_rd_i == '0);

    // Hazard/limit check uses registered state only; a write-back landing this
    // cycle does not unblock issue until the following cycle.
    always_comb begin
        issue_ready_o = !rst_i && start_i
                        && !(issue_use_i[0] && busy_reg[issue_rs1_i])
                        && !(issue_use_i[1] && busy_reg[issue_rs2_i])
                        && !(issue_wen_i && busy_reg[issue_rd_i])
                        && ((cnt_reg < CNT_W'(MAX_OUTSTANDING)) || !issue_wen_i || rd_is_zero);
    end

    assign accept = issue_valid_i && issue_ready_o;

    // Merge write-back ports; a clear of an idle register or two ports naming
    // the same register in one cycle is a protocol error.
    always_comb begin
        wb_hit = '0;
        wb_err = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_hit = wb_hit | wb_dec[k];
            if (wb_valid_i[k] && ((wb_dec[k] & busy_reg) == '0)) begin
                wb_err = 1'b1;
            end
            for (int j = 0; j < k; j++) begin
                if (wb_valid_i[j] && wb_valid_i[k] && (wb_dec[j] == wb_dec[k])) begin
                    wb_err = 1'b1;
                end
            end
        end
    end

    // Entries leaving the scoreboard this cycle: write-back clears plus, on a
    // flush, every speculative entry.
    always_comb begin
        removed_mask = busy_reg & (wb_hit | (flush_i ? spec_reg : '0));
        set_mask     = '0;
        if (accept && issue_wen_i && !rd_is_zero && !(flush_i && issue_spec_i)) begin
            set_mask = rd_dec;
        end
    end

    sb_popcount #(.N(NUM_REGS), .CW(POP_W)) u_pop_removed (
        .bits  (removed_mask),
        .count (removed_cnt)
    );

    sb_popcount #(.N(NUM_REGS), .CW(POP_W)) u_pop_busy (
        .bits  (busy_reg),
        .count (busy_cnt)
    );

    // Next state; a new entry can never collide with a removed one because
    // issue already required its destination to be idle.
    always_comb begin
        busy_next = (busy_reg & ~removed_mask) | set_mask;
        spec_next = spec_reg & ~removed_mask;
        if (resolve_i && !flush_i) begin
            spec_next = '0;
        end
        if (issue_spec_i) begin
            spec_next = spec_next | set_mask;
        end
        cnt_next = cnt_reg - CNT_W'(removed_cnt) + CNT_W'(|set_mask);
        err_next = err_reg | wb_err;
    end

    // State register; start_i low freezes everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_reg <= '0;
            spec_reg <= '0;
            cnt_reg  <= '0;
            err_reg  <= 1'b0;
        end else if (start_i) begin
            busy_reg <= busy_next;
            spec_reg <= spec_next;
            cnt_reg  <= cnt_next;
            err_reg  <= err_next;
        end
    end

    assign busy_o        = busy_reg;
    assign outstanding_o = cnt_reg;
    assign err_o         = err_reg;

    // Counter must always match the busy vector and respect the limit.
    assert property (@(posedge clk_i) disable iff (rst_i)
        (POP_W'(cnt_reg) == busy_cnt) && (cnt_reg <= CNT_W'(MAX_OUTSTANDING)));

    // Register 0 never becomes busy when hardwired.
    generate
        if (ZERO_HARDWIRED != 0) begin : g_zero_chk
            assert property (@(posedge clk_i) disable iff (rst_i) !busy_reg[0]);
        end
    endgenerate

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, outstanding limit, flush/resolve,
// write-back errors, start gating and asynchronous reset.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [1:0]  issue_use;
    logic        issue_wen;
    logic [4:0]  issue_rd;
    logic        issue_spec;
    logic        issue_ready;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic        resolve;
    logic        flush;
    logic [31:0] busy;
    logic [2:0]  outstanding;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .issue_valid_i (issue_valid),
        .issue_rs1_i   (issue_rs1),
        .issue_rs2_i   (issue_rs2),
        .issue_use_i   (issue_use),
        .issue_wen_i   (issue_wen),
        .issue_rd_i    (issue_rd),
        .issue_spec_i  (issue_spec),
        .issue_ready_o (issue_ready),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .resolve_i     (resolve),
        .flush_i       (flush),
        .busy_o        (busy),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_use = '0;
        issue_wen = 1'b0; issue_rd = '0; issue_spec = 1'b0;
        wb_valid = '0; wb_rd = '0; resolve = 1'b0; flush = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] u,
                             input logic wen, input logic [4:0] rd, input logic spec);
        issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_use = u;
        issue_wen = wen; issue_rd = rd; issue_spec = spec;
    endtask

    task automatic set_wb(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1);
        wb_valid = v;
        wb_rd    = {rd1, rd0};
    endtask

    // One clock edge, then the per-cycle invariants and a transaction line.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t busy=%08h outstanding=%0d err=%0b", $time, busy, outstanding, err);
        chk("inv_count", 32'(outstanding), 32'($countones(busy)));
        chk("busy_r0", 32'(busy[0]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle();
        rst = 1'b1;
        start = 1'b1;
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd1, 1'b0);
        #2;
        chk("rst_ready", 32'(issue_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 32'h0);
        chk("rst_cnt", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        idle();
        tick();

        // Fill 4..7, set err, then reset mid-run
        for (int r = 4; r < 8; r++) begin
            set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'(r), 1'b0);
            tick();
        end
        idle();
        chk("fill_busy", busy, 32'h0000_00F0);
        chk("fill_cnt", 32'(outstanding), 32'd4);
        set_wb(2'b01, 5'd20, 5'd0);
        tick();
        idle();
        chk("idle_wb_err", 32'(err), 32'd1);
        chk("idle_wb_busy", busy, 32'h0000_00F0);
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd1, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 32'h0);
        chk("mid_rst_cnt", 32'(outstanding), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_ready", 32'(issue_ready), 32'd0);
        rst = 1'b0;
        idle();
        tick();

        // RAW on rs1, no same-cycle write-back bypass
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b0);
        tick();
        chk("raw_busy", busy, 32'h0000_0020);
        set_issue(5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0);
        #1;
        chk("raw_ready", 32'(issue_ready), 32'd0);
        tick();
        set_wb(2'b01, 5'd5, 5'd0);
        #1;
        chk("raw_wb_same_cycle", 32'(issue_ready), 32'd0);
        tick();
        set_wb(2'b00, 5'd0, 5'd0);
        #1;
        chk("raw_wb_next_cycle", 32'(issue_ready), 32'd1);
        chk("raw_cleared", busy, 32'h0);
        tick();

        // rs2 hazard, use-mask masking, WAW
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0);
        tick();
        set_issue(5'd0, 5'd9, 2'b10, 1'b0, 5'd0, 1'b0);
        #1;
        chk("rs2_ready", 32'(issue_ready), 32'd0);
        set_issue(5'd0, 5'd9, 2'b01, 1'b0, 5'd0, 1'b0);
        #1;
        chk("rs2_unused_ready", 32'(issue_ready), 32'd1);
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0);
        #1;
        chk("waw_ready", 32'(issue_ready), 32'd0);
        idle();
        set_wb(2'b01, 5'd9, 5'd0);
        tick();
        idle();
        chk("waw_cleared_cnt", 32'(outstanding), 32'd0);

        // Outstanding limit
        for (int r = 1; r < 5; r++) begin
            set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'(r), 1'b0);
            tick();
        end
        chk("lim_busy", busy, 32'h0000_001E);
        chk("lim_cnt", 32'(outstanding), 32'd4);
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 1'b0);
        #1;
        chk("lim_rd6_ready", 32'(issue_ready), 32'd0);
        set_issue(5'd0, 5'd0, 2'b00, 1'b0, 5'd6, 1'b0);
        #1;
        chk("lim_nowen_ready", 32'(issue_ready), 32'd1);
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lim_rd0_ready", 32'(issue_ready), 32'd1);
        tick();
        idle();
        chk("lim_rd0_busy", busy, 32'h0000_001E);
        chk("lim_rd0_cnt", 32'(outstanding), 32'd4);
        set_wb(2'b11, 5'd1, 5'd2);
        tick();
        chk("dual_wb_cnt", 32'(outstanding), 32'd2);
        // Same-cycle issue and two write-backs
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 1'b0);
        set_wb(2'b11, 5'd3, 5'd4);
        tick();
        idle();
        chk("iss_wb_busy", busy, 32'h0000_0040);
        chk("iss_wb_cnt", 32'(outstanding), 32'd1);
        set_wb(2'b01, 5'd6, 5'd0);
        tick();
        idle();

        // Flush with speculative issue and write-back in the same cycle
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b0);
        tick();
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1);
        tick();
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1);
        tick();
        chk("fl_pre_busy", busy, 32'h0000_0288);
        chk("fl_pre_cnt", 32'(outstanding), 32'd3);
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 1'b1);
        set_wb(2'b01, 5'd3, 5'd0);
        flush = 1'b1;
        #1;
        chk("fl_ready", 32'(issue_ready), 32'd1);
        tick();
        idle();
        chk("fl_busy", busy, 32'h0);
        chk("fl_cnt", 32'(outstanding), 32'd0);
        chk("fl_err", 32'(err), 32'd0);

        // Flush keeps a same-cycle non-speculative accept
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd11, 1'b1);
        tick();
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd12, 1'b0);
        flush = 1'b1;
        tick();
        idle();
        chk("fl_keep_busy", busy, 32'h0000_1000);
        chk("fl_keep_cnt", 32'(outstanding), 32'd1);
        set_wb(2'b01, 5'd12, 5'd0);
        tick();
        idle();

        // Resolve commits speculation; flush with resolve wins
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1);
        tick();
        idle();
        resolve = 1'b1;
        tick();
        idle();
        flush = 1'b1;
        tick();
        idle();
        chk("res_busy", busy, 32'h0000_0100);
        chk("res_cnt", 32'(outstanding), 32'd1);
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd14, 1'b1);
        tick();
        idle();
        resolve = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        chk("res_fl_busy", busy, 32'h0000_0100);
        chk("res_fl_cnt", 32'(outstanding), 32'd1);
        set_wb(2'b01, 5'd8, 5'd0);
        tick();
        idle();
        chk("pre_dup_err", 32'(err), 32'd0);

        // Duplicate write-back ports, then write-back to an idle register
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd12, 1'b0);
        tick();
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd15, 1'b0);
        tick();
        idle();
        set_wb(2'b11, 5'd12, 5'd12);
        tick();
        idle();
        chk("dup_busy", busy, 32'h0000_8000);
        chk("dup_cnt", 32'(outstanding), 32'd1);
        chk("dup_err", 32'(err), 32'd1);
        set_wb(2'b01, 5'd13, 5'd0);
        tick();
        idle();
        chk("nb_busy", busy, 32'h0000_8000);
        chk("nb_cnt", 32'(outstanding), 32'd1);
        chk("nb_err", 32'(err), 32'd1);

        // start low freezes state and blocks issue
        start = 1'b0;
        set_issue(5'd0, 5'd0, 2'b00, 1'b1, 5'd20, 1'b0);
        set_wb(2'b01, 5'd15, 5'd0);
        flush = 1'b1;
        #1;
        chk("stop_ready", 32'(issue_ready), 32'd0);
        tick();
        idle();
        chk("stop_busy", busy, 32'h0000_8000);
        chk("stop_cnt", 32'(outstanding), 32'd1);
        start = 1'b1;
        set_wb(2'b01, 5'd15, 5'd0);
        tick();
        idle();
        chk("end_busy", busy, 32'h0);
        chk("end_cnt", 32'(outstanding), 32'd0);
        chk("end_err", 32'(err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
